tsv_onehot_mux_array: RTL
=========================

// Module: tsv_onehot_mux_array
// PURPOSE
//  Parametrised, registered bank of one-hot AND-OR selectors for a TSV array. Each of N_TSV
//  output TSV bits selects one of N_SRC candidate codec bits (or is disabled).
//  Selection is reconfigured at run time through a validated, handshaked config port.
//  A new config takes effect only after the output stage drains, so no beat mixes two configs.
//  Sits between the CAC encoder output and the physical TSV drivers (repair/remap path).
// PARAMETERS
//  N_TSV   7  number of output TSV bits (Hex7 array)
//  N_SRC   3  candidate sources per TSV; select field per TSV is N_SRC bits, one-hot
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             synchronous reset, active-high
//  cfg_valid   in   1             new select map offered
//  cfg_ready   out  1             config accepted when cfg_valid & cfg_ready
//  cfg_sel     in   N_TSV*N_SRC   select map; field t = cfg_sel[t*N_SRC +: N_SRC]
//  cfg_err     out  1             1-cycle pulse: offered map rejected (multi-hot field)
//  sel_active  out  N_TSV*N_SRC   select map currently applied
//  in_valid    in   1             input beat valid
//  in_ready    out  1             input beat accepted when in_valid & in_ready
//  in_data     in   N_TSV*N_SRC   candidates; group t = in_data[t*N_SRC +: N_SRC]
//  out_valid   out  1             registered output beat valid
//  out_ready   in   1             downstream accepts beat
//  out_data    out  N_TSV         out_data[t] = |(in_data group t & sel_active field t)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=ACTIVE; sel_active = every field 'b0..01 (source 0);
//   out_valid=0, out_data=0, cfg_err=0, pending map=0. Reset wins over all other events.
//  Field legality: all-zero (TSV disabled, drives 0) or exactly one bit set. Any field with
//   >1 bit set makes the whole map illegal.
//  Datapath: 1 register stage, latency 1 cycle, full throughput.
//   in_ready = (state==ACTIVE) & (~out_valid | out_ready).
//   On in fire: out_data <= mux(in_data, sel_active), out_valid <= 1.
//   Else if out_valid & out_ready: out_valid <= 0; out_data holds last value.
//   out_data/out_valid stable while out_valid & ~out_ready.
//  FSM states ACTIVE, DRAIN, APPLY:
//   ACTIVE: cfg_ready=1. cfg fire with legal map -> pending <= cfg_sel, go DRAIN.
//    cfg fire with illegal map -> cfg_err=1 next cycle, stay ACTIVE, sel_active unchanged.
//    cfg fire and in fire in the same cycle: the data beat uses the OLD map.
//   DRAIN: cfg_ready=0, in_ready=0. Go APPLY when out stage empty next cycle
//    (out_valid==0, or out_valid & out_ready this cycle). Waits indefinitely under backpressure.
//   APPLY: 1 cycle, cfg_ready=0, in_ready=0; sel_active <= pending; go ACTIVE.
//  Minimum gap from cfg fire to first beat on the new map: 2 cycles when the out stage
//   is empty (DRAIN, APPLY); accepted on the 3rd cycle.
//  cfg_err is never asserted for a legal map. It never stays high more than 1 cycle
//   unless illegal maps are offered back-to-back.
//  Reset during DRAIN/APPLY: pending map discarded, reset defaults applied.
// TESTING
//  1 Reset, then in_data=all 'b001 groups, in_valid=1 -> out_data=7'h7F one cycle later,
//    sel_active=21'h049249.
//  2 Stream 8 beats at full rate, out_ready=1 -> 8 consecutive out_valid, latency 1, no bubbles.
//  3 Mid-stream cfg_sel = all fields 'b100, out_ready=0 for 3 cycles -> in_ready=0 through DRAIN.
//    APPLY follows 1 cycle after out drains; next beat uses source 2.
//  4 cfg_sel field 0='b011 -> cfg_err pulses 1 cycle, sel_active unchanged, data continues.
//  5 Field 3 = 'b000 -> out_data[3]=0 for all in_data, other bits unaffected.
//  6 rst asserted during DRAIN -> next cycle state ACTIVE, sel_active = default, out_valid=0.

Source files
------------

// File: rtl/tsv_onehot_mux_array.sv
// Registered bank of one-hot AND-OR selectors for a TSV array.
// The select map is swapped only after the output stage drains, so no beat mixes two maps.
module tsv_onehot_mux_array #(
  parameter int N_TSV = 7,
  parameter int N_SRC = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [N_TSV*N_SRC-1:0]   cfg_sel,
  output logic                     cfg_err,
  output logic [N_TSV*N_SRC-1:0]   sel_active,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_TSV*N_SRC-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_TSV-1:0]         out_data
);

  localparam logic [N_SRC-1:0] FIELD_ONE = N_SRC'(1);

  function automatic logic [N_TSV*N_SRC-1:0] default_sel();
    logic [N_TSV*N_SRC-1:0] r;
    r = '0;
    for (int t = 0; t < N_TSV; t++) r[t*N_SRC] = 1'b1;
    return r;
  endfunction

  localparam logic [N_TSV*N_SRC-1:0] SEL_DEFAULT = default_sel();

  typedef enum logic [1:0] {ACTIVE, DRAIN, APPLY} state_t;

  state_t                   state_q, state_d;
  logic [N_TSV*N_SRC-1:0]   pending_q;
  logic                     cfg_legal;
  logic                     cfg_fire;
  logic                     in_fire;
  logic                     out_free;
  logic [N_TSV-1:0]         mux_out;

  // A field is legal when clearing its lowest set bit leaves nothing.
  always_comb begin
    logic [N_SRC-1:0] f;
    f         = '0;
    cfg_legal = 1'b1;
    for (int t = 0; t < N_TSV; t++) begin
      f = cfg_sel[t*N_SRC +: N_SRC];
      if ((f & (f - FIELD_ONE)) != '0) cfg_legal = 1'b0;
    end
  end

  always_comb begin
    mux_out = '0;
    for (int t = 0; t < N_TSV; t++)
      mux_out[t] = |(in_data[t*N_SRC +: N_SRC] & sel_active[t*N_SRC +: N_SRC]);
  end

  assign out_free  = ~out_valid | out_ready;
  assign cfg_ready = (state_q == ACTIVE);
  assign in_ready  = (state_q == ACTIVE) & out_free;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign in_fire   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE:  if (cfg_fire && cfg_legal) state_d = DRAIN;
      DRAIN:   if (out_free) state_d = APPLY;
      APPLY:   state_d = ACTIVE;
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACTIVE;
      sel_active <= SEL_DEFAULT;
      pending_q  <= '0;
      cfg_err    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state_q <= state_d;
      cfg_err <= cfg_fire & ~cfg_legal;
      if (cfg_fire && cfg_legal) pending_q <= cfg_sel;
      if (state_q == APPLY) sel_active <= pending_q;
      if (in_fire) begin
        out_data  <= mux_out;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
